// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus request/response types and arbiter state encoding.
// Used by cbus_arbiter (optional round-robin policy: CBUS_ARB_ROUND_ROBIN_EN).
package cbus_arbiter_pkg;

   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } mlen_t;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } mburst_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      mlen_t       len;
      mburst_t     burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Index increment with wrap at n-1 -> 0.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cbus_arb_select.sv
// Combinational picker: first valid index scanning from rr_ptr with modulo wrap.
// With rr_ptr tied to 0 this degenerates to lowest-index-wins fixed priority.
module cbus_arb_select
   import cbus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_BITS    = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] valid,
   input  logic [IDX_BITS-1:0]    rr_ptr,
   output logic [IDX_BITS-1:0]    sel,
   output logic                   any
);

   always_comb begin
      logic found;
      int   idx;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_MASTERS;
         if (!found && valid[IDX_BITS'(idx)]) begin
            sel   = IDX_BITS'(idx);
            found = 1'b1;
         end
      end
   end

   assign any = |valid;

endmodule

// File: rtl/cbus_arbiter.sv
// Burst-level arbiter of N cbus masters onto one memory port; grant held until last beat.
// Policy: fixed priority by default, round-robin when CBUS_ARB_ROUND_ROBIN_EN is defined.
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   localparam int IDX_BITS    = $clog2(NUM_MASTERS)
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  ireqs  [NUM_MASTERS],
   output cbus_resp_t oresps [NUM_MASTERS],
   output cbus_req_t  oreq,
   input  cbus_resp_t iresp,
   output arb_state_t dbg_state
);

   // Handshake: a beat transfers in BUSY when iresp.ready=1; the burst ends on ready && last.
   arb_state_t             state;
   logic [IDX_BITS-1:0]    grant;
   logic [IDX_BITS-1:0]    sel;
   logic [IDX_BITS-1:0]    scan_start;
   logic [NUM_MASTERS-1:0] valid_vec;
   logic                   any_valid;
   logic                   burst_done;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
   logic [IDX_BITS-1:0] rr_ptr;
   assign scan_start = rr_ptr;
`else
   assign scan_start = '0;
`endif

   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < NUM_MASTERS; i++) valid_vec[i] = ireqs[i].valid;
   end

   cbus_arb_select #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_BITS    (IDX_BITS)
   ) u_select (
      .valid  (valid_vec),
      .rr_ptr (scan_start),
      .sel    (sel),
      .any    (any_valid)
   );

   assign burst_done = iresp.ready && iresp.last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
         rr_ptr <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  state <= BUSY;
                  grant <= sel;
               end
            end
            BUSY: begin
               if (burst_done) begin
                  state <= IDLE;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                  rr_ptr <= IDX_BITS'(wrap_inc(int unsigned'(grant), NUM_MASTERS));
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory responses seen while IDLE are dropped here, never forwarded.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_MASTERS; i++) oresps[i] = '0;
      if (state == BUSY) begin
         oreq          = ireqs[grant];
         oresps[grant] = iresp;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomised bench for cbus_arbiter: bench-side masters and memory, burst-level reference model.
// Follows CBUS_ARB_ROUND_ROBIN_EN for the expected policy.
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   localparam int NM = 2;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   cbus_req_t  ireqs  [NM];
   cbus_resp_t oresps [NM];
   cbus_req_t  oreq;
   cbus_resp_t iresp;
   arb_state_t dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Expected delivered beats in order: {master index, data}.
   logic [64:0] exp_q[$];

   // Reference model: owner of the bus (-1 = nobody) and round-robin start point.
   int mdl_owner = -1;
   int mdl_ptr   = 0;
   int nxt_owner;
   int nxt_ptr;
   int mem_beat  = 0;
   bit done_pend [NM];
   bit beat_pend [NM];
   int m_gap     [NM];
   bit rand_mode = 1'b0;
   bit spur      = 1'b0;

   cbus_arbiter #(.NUM_MASTERS(NM)) dut (
      .clk       (clk),
      .reset     (reset),
      .ireqs     (ireqs),
      .oresps    (oresps),
      .oreq      (oreq),
      .iresp     (iresp),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int pick();
      int start;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      start = mdl_ptr;
`else
      start = 0;
`endif
      for (int k = 0; k < NM; k++)
         if (ireqs[(start + k) % NM].valid) return (start + k) % NM;
      return -1;
   endfunction

   task automatic arm(input int i, input bit wr, input logic [31:0] addr, input mlen_t len);
      ireqs[i].valid    = 1'b1;
      ireqs[i].is_write = wr;
      ireqs[i].size     = 3'd3;
      ireqs[i].addr     = addr;
      ireqs[i].strobe   = wr ? 8'hFF : 8'h00;
      ireqs[i].data     = wr ? {$urandom, $urandom} : 64'd0;
      ireqs[i].len      = len;
      ireqs[i].burst    = BURST_INCR;
   endtask

   task automatic arm_random(input int i);
      mlen_t len;
      case ($urandom_range(0, 4))
         0:       len = MLEN1;
         1:       len = MLEN2;
         2:       len = MLEN4;
         3:       len = MLEN8;
         default: len = MLEN16;
      endcase
      arm(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFC0, len);
   endtask

   task automatic drive_mem();
      iresp = '0;
      if (mdl_owner >= 0) begin
         if (ireqs[mdl_owner].valid && $urandom_range(0, 3) != 0) begin
            iresp.ready = 1'b1;
            iresp.data  = {$urandom, $urandom};
            iresp.last  = (mem_beat == int'(ireqs[mdl_owner].len));
         end
      end else if (spur || (rand_mode && $urandom_range(0, 15) == 0)) begin
         iresp.ready = 1'b1;
         iresp.last  = 1'b1;
         iresp.data  = {$urandom, $urandom};
      end
   endtask

   task automatic check_outputs();
      cbus_req_t   er;
      cbus_resp_t  es;
      arb_state_t  est;
      logic [64:0] e;
      er  = '0;
      est = IDLE;
      if (mdl_owner >= 0) begin
         er  = ireqs[mdl_owner];
         est = BUSY;
      end
      check("oreq", 128'(oreq), 128'(er));
      check("state", 128'(dbg_state), 128'(est));
      for (int i = 0; i < NM; i++) begin
         es = '0;
         if (mdl_owner == i) es = iresp;
         check($sformatf("oresps%0d", i), 128'(oresps[i]), 128'(es));
      end
      if (mdl_owner >= 0 && iresp.ready) exp_q.push_back({1'(mdl_owner), iresp.data});
      for (int i = 0; i < NM; i++) begin
         if (oresps[i].ready) begin
            e = 'x;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("sb_beat", 128'({i[0], oresps[i].data}), 128'(e));
         end
      end
   endtask

   task automatic compute_next();
      nxt_owner = mdl_owner;
      nxt_ptr   = mdl_ptr;
      for (int i = 0; i < NM; i++) begin
         done_pend[i] = 1'b0;
         beat_pend[i] = 1'b0;
      end
      if (reset) begin
         nxt_owner = -1;
         nxt_ptr   = 0;
         mem_beat  = 0;
      end else if (mdl_owner < 0) begin
         nxt_owner = pick();
      end else if (iresp.ready) begin
         beat_pend[mdl_owner] = 1'b1;
         if (iresp.last) begin
            nxt_owner            = -1;
            nxt_ptr              = (mdl_owner + 1) % NM;
            done_pend[mdl_owner] = 1'b1;
            mem_beat             = 0;
         end else begin
            mem_beat++;
         end
      end
   endtask

   task automatic commit();
      mdl_owner = nxt_owner;
      mdl_ptr   = nxt_ptr;
      for (int i = 0; i < NM; i++) begin
         if (done_pend[i]) begin
            ireqs[i].valid = 1'b0;
            m_gap[i]       = $urandom_range(0, 3);
         end else if (beat_pend[i] && ireqs[i].is_write) begin
            ireqs[i].data = {$urandom, $urandom};
         end
         if (rand_mode && !ireqs[i].valid && !done_pend[i]) begin
            if (m_gap[i] > 0) m_gap[i]--;
            else if ($urandom_range(0, 2) == 0) arm_random(i);
         end
      end
   endtask

   task automatic run_cycle();
      drive_mem();
      @(negedge clk);
      check_outputs();
      compute_next();
      @(posedge clk);
      #1;
      commit();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((mdl_owner >= 0 || ireqs[0].valid || ireqs[1].valid) && n < budget) begin
         run_cycle();
         n++;
      end
      check("wait_idle_timeout", 128'(n >= budget), 128'(0));
   endtask

   initial begin
      int n;
      for (int i = 0; i < NM; i++) begin
         ireqs[i] = '0;
         m_gap[i] = 0;
      end
      iresp = '0;

      // Reset held with master 0 requesting; grant must appear right after release.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      arm(0, 1'b0, 32'h0000_1000, MLEN4);
      repeat (3) run_cycle();
      reset = 1'b0;
      wait_idle(200);

      // Single 16-beat read from master 1.
      arm(1, 1'b0, 32'h8000_0040, MLEN16);
      wait_idle(200);

      // Simultaneous read (M0) and write (M1).
      arm(0, 1'b0, 32'h0000_0100, MLEN8);
      arm(1, 1'b1, 32'h0000_0200, MLEN4);
      wait_idle(200);

      // Spurious memory response while idle.
      spur = 1'b1;
      repeat (3) run_cycle();
      spur = 1'b0;

      // Reset after beat 5 of 16; master 1 keeps requesting and is re-granted.
      arm(1, 1'b0, 32'h8000_0080, MLEN16);
      n = 0;
      while (!(mdl_owner == 1 && mem_beat == 5) && n < 200) begin
         run_cycle();
         n++;
      end
      check("beat5_timeout", 128'(n >= 200), 128'(0));
      reset = 1'b1;
      run_cycle();
      reset = 1'b0;
      wait_idle(200);

      // Random traffic with occasional resets and spurious responses.
      rand_mode = 1'b1;
      repeat (3000) begin
         reset = ($urandom_range(0, 299) == 0);
         run_cycle();
      end
      reset     = 1'b0;
      rand_mode = 1'b0;
      wait_idle(400);
      check("sb_leftover", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
